// File: rtl/result_select_pipe.sv
// result_select_pipe: NUM_IN:1 result mux registered behind a valid/ready handshake with a 2-entry skid buffer.
// Flags zero results and out-of-range selects, and keeps a saturating count of bad selects.
module result_select_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 5,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_zero,
    output logic                    out_sel_err,
    input  logic                    err_clr,
    output logic [CNT_W-1:0]        err_count
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state_q, state_d;
    logic accept, emit, bad_accept;
    logic in_ready_q, in_ready_d;
    logic [WIDTH-1:0] mux_data;
    logic mux_err;
    // Each entry packs {data, zero, err}; entry validity is implied by the state.
    logic [WIDTH+1:0] new_item, oreg_q, oreg_d, skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign accept     = in_valid && in_ready_q;
    assign emit       = out_valid && out_ready;
    assign bad_accept = accept && mux_err;
    assign new_item   = {mux_data, mux_data == '0, mux_err};

    always_comb begin
        mux_data = '0;
        mux_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                mux_data = in_bus[k*WIDTH +: WIDTH];
                mux_err  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            oreg_q     <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            oreg_q     <= oreg_d;
            skid_q     <= skid_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   state_d = accept ? ONE : EMPTY;
            ONE:     state_d = (accept && !emit) ? FULL : (!accept && emit) ? EMPTY : ONE;
            FULL:    state_d = emit ? ONE : FULL;
            default: state_d = EMPTY;
        endcase
    end

    // in_ready is registered from the next state, so FULL never sees an accept.
    always_comb begin
        oreg_d     = oreg_q;
        skid_d     = skid_q;
        in_ready_d = (state_d != FULL);
        if (state_q == FULL) begin
            if (emit) oreg_d = skid_q;
        end else if (accept && (state_q == EMPTY || emit)) begin
            oreg_d = new_item;
        end else if (accept) begin
            skid_d = new_item;
        end
        cnt_d = err_clr ? CNT_W'(bad_accept) : (bad_accept && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign out_data    = oreg_q[WIDTH+1:2];
    assign out_zero    = oreg_q[1];
    assign out_sel_err = oreg_q[0];
    assign err_count   = cnt_q;
endmodule

// File: tb/tb_result_select_pipe.sv
// tb_result_select_pipe: directed and randomized checks of result_select_pipe at default width
// and at an 8-bit, 16-input configuration.
module tb_result_select_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid0, in_ready0, out_valid0, out_ready0, out_zero0, out_sel_err0, err_clr0;
    logic [2:0]  sel0;
    logic [31:0] w0 [5];
    logic [159:0] bus0;
    logic [31:0] out_data0;
    logic [7:0]  err_count0;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, out_zero1, out_sel_err1, err_clr1;
    logic [3:0]  sel1;
    logic [7:0]  w1 [16];
    logic [127:0] bus1;
    logic [7:0]  out_data1;
    logic [7:0]  err_count1;

    for (genvar g = 0; g < 5; g++) assign bus0[g*32 +: 32] = w0[g];
    for (genvar g = 0; g < 16; g++) assign bus1[g*8 +: 8] = w1[g];

    result_select_pipe u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .sel(sel0),
        .in_bus(bus0), .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .out_zero(out_zero0), .out_sel_err(out_sel_err0), .err_clr(err_clr0), .err_count(err_count0)
    );

    result_select_pipe #(.WIDTH(8), .NUM_IN(16), .SEL_W(4), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .sel(sel1),
        .in_bus(bus1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_zero(out_zero1), .out_sel_err(out_sel_err1), .err_clr(err_clr1), .err_count(err_count1)
    );

    int checks = 0;
    int errors = 0;
    int emits0 = 0;
    int zeros1 = 0;
    logic [33:0] q0 [$];
    logic [9:0]  q1 [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] model0(input logic [2:0] s);
        logic [31:0] d;
        d = (s < 3'd5) ? w0[s] : 32'h0;
        return {d, d == 32'h0, s >= 3'd5};
    endfunction

    function automatic logic [9:0] model1(input logic [3:0] s);
        return {w1[s], w1[s] == 8'h0, 1'b0};
    endfunction

    // One clock: score emits and accepts seen before the edge, then land 1 time unit after it.
    task automatic step;
        logic a0, e0, a1, e1;
        a0 = in_valid0 && in_ready0;
        e0 = out_valid0 && out_ready0;
        a1 = in_valid1 && in_ready1;
        e1 = out_valid1 && out_ready1;
        if (e0) begin
            emits0++;
            if (q0.size() == 0) chk("sb0_underflow", 64'(1), 64'(0));
            else chk("sb0_emit", 64'({out_data0, out_zero0, out_sel_err0}), 64'(q0.pop_front()));
        end
        if (a0) q0.push_back(model0(sel0));
        if (e1) begin
            if (out_zero1) zeros1++;
            if (q1.size() == 0) chk("sb1_underflow", 64'(1), 64'(0));
            else chk("sb1_emit", 64'({out_data1, out_zero1, out_sel_err1}), 64'(q1.pop_front()));
        end
        if (a1) q1.push_back(model1(sel1));
        @(posedge clk);
        #1;
    endtask

    task automatic walk_data;
        for (int k = 0; k < 5; k++) w0[k] = 32'h11111111 * (k + 1);
    endtask

    initial begin
        int sent, e_start;
        rst_n = 1'b1;
        in_valid0 = 0; out_ready0 = 1; err_clr0 = 0; sel0 = 0;
        in_valid1 = 0; out_ready1 = 1; err_clr1 = 0; sel1 = 0;
        walk_data();
        for (int k = 0; k < 16; k++) w1[k] = 8'h0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready0), 64'(0));
        chk("rst_out_valid", 64'(out_valid0), 64'(0));
        chk("rst_out_data", 64'(out_data0), 64'(0));
        chk("rst_flags", 64'({out_zero0, out_sel_err0}), 64'(0));
        chk("rst_err_count", 64'(err_count0), 64'(0));
        chk("rst_out_valid1", 64'(out_valid1), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rel_in_ready_low", 64'(in_ready0), 64'(0));
        step();
        chk("rel_in_ready_high", 64'(in_ready0), 64'(1));

        // back-to-back walk through all valid selects
        in_valid0 = 1;
        for (int k = 0; k < 5; k++) begin
            sel0 = 3'(k);
            step();
            chk("walk_valid", 64'(out_valid0), 64'(1));
            chk("walk_data", 64'(out_data0), 64'(32'h11111111 * (k + 1)));
            chk("walk_flags", 64'({out_zero0, out_sel_err0}), 64'(0));
            chk("walk_in_ready", 64'(in_ready0), 64'(1));
        end
        in_valid0 = 0;
        step();
        chk("walk_drain_valid", 64'(out_valid0), 64'(0));
        chk("walk_err_count", 64'(err_count0), 64'(0));

        // out-of-range selects
        for (int k = 0; k < 5; k++) w0[k] = 32'hFFFFFFFF;
        in_valid0 = 1;
        for (int s = 5; s < 8; s++) begin
            sel0 = 3'(s);
            step();
            chk("bad_data", 64'(out_data0), 64'(0));
            chk("bad_flags", 64'({out_zero0, out_sel_err0}), 64'(2'b11));
        end
        in_valid0 = 0;
        step();
        chk("bad_err_count", 64'(err_count0), 64'(3));

        // back-pressure: 6 items, out_ready low for 4 cycles from the third accept
        walk_data();
        sent = 0;
        e_start = emits0;
        for (int c = 0; c < 16; c++) begin
            out_ready0 = !(c >= 2 && c < 6);
            in_valid0 = (sent < 6);
            sel0 = 3'(sent % 5);
            if (in_valid0 && in_ready0) sent++;
            step();
            if (c >= 2 && c < 6) begin
                chk("bp_in_ready_full", 64'(in_ready0), 64'(0));
                chk("bp_hold_data", 64'(out_data0), 64'(32'h22222222));
                chk("bp_hold_valid", 64'(out_valid0), 64'(1));
            end
        end
        chk("bp_sent", 64'(sent), 64'(6));
        chk("bp_emitted", 64'(emits0 - e_start), 64'(6));
        chk("bp_queue_empty", 64'(q0.size()), 64'(0));

        // saturation and clear
        out_ready0 = 1;
        in_valid0 = 0;
        err_clr0 = 1;
        step();
        chk("clr_alone_pre", 64'(err_count0), 64'(0));
        err_clr0 = 0;
        in_valid0 = 1;
        sel0 = 3'd7;
        repeat (254) step();
        chk("sat_254", 64'(err_count0), 64'(254));
        repeat (6) step();
        chk("sat_255", 64'(err_count0), 64'(255));
        err_clr0 = 1;
        step();
        chk("clr_with_bad", 64'(err_count0), 64'(1));
        in_valid0 = 0;
        step();
        chk("clr_alone", 64'(err_count0), 64'(0));
        err_clr0 = 0;

        // reset while FULL
        out_ready0 = 0;
        in_valid0 = 1;
        sel0 = 3'd5;
        step();
        sel0 = 3'd1;
        step();
        in_valid0 = 0;
        chk("mid_full_in_ready", 64'(in_ready0), 64'(0));
        chk("mid_err_count", 64'(err_count0), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid0), 64'(0));
        chk("mid_rst_err_count", 64'(err_count0), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready0), 64'(0));
        q0.delete();
        @(negedge clk) rst_n = 1'b1;
        #1 step();
        chk("mid_rel_in_ready", 64'(in_ready0), 64'(1));
        chk("mid_rel_valid", 64'(out_valid0), 64'(0));
        in_valid0 = 1;
        sel0 = 3'd2;
        out_ready0 = 1;
        step();
        chk("mid_first_valid", 64'(out_valid0), 64'(1));
        chk("mid_first_data", 64'(out_data0), 64'(32'h33333333));
        in_valid0 = 0;
        step();

        // 8-bit, 16-input random sweep
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 16; k++) w1[k] = ($urandom_range(3) == 0) ? 8'h0 : 8'($urandom);
            sel1 = 4'($urandom);
            in_valid1 = 1'($urandom_range(1));
            out_ready1 = 1'($urandom_range(1));
            step();
        end
        in_valid1 = 0;
        out_ready1 = 1;
        repeat (20) step();
        chk("sweep_drained", 64'(q1.size()), 64'(0));
        chk("sweep_zero_seen", 64'(zeros1 > 0), 64'(1));
        chk("sweep_err_count", 64'(err_count1), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end
endmodule
